midi_uart_tx: RTL and testbench



---
 rtl/midi_uart_tx.sv | 122 ++++++++++++
 tb/tb_midi_uart_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_tx.sv
// MIDI serial transmitter: 8N1 frames at BAUD, one byte per tstart/tready handshake.
// Optional running-status compression when MIDI_TX_RUNNING_STATUS_EN is defined.
module midi_uart_tx #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 31250
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tbus,
  input  logic       tstart,
  output logic       tready,
  output logic       txd
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("midi_uart_tx: CLK_HZ/BAUD must be at least 4");
  end

  logic [1:0]       state;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             bit_done;
  logic             send_ok;

  assign bit_done = (baud_cnt == CNT_TC);
  assign tready   = (state == IDLE) && !tstart;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status;
  logic       is_chan_status;
  logic       is_sys_common;

  assign is_chan_status = (tbus >= 8'h80) && (tbus <= 8'hEF);
  assign is_sys_common  = (tbus >= 8'hF0) && (tbus <= 8'hF7);
  assign send_ok        = !(is_chan_status && (tbus == last_status));

  // Realtime and data bytes leave the running status untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_status <= '0;
    end else if ((state == IDLE) && tstart) begin
      if (is_chan_status && send_ok)
        last_status <= tbus;
      else if (is_sys_common)
        last_status <= '0;
    end
  end
`else
  assign send_ok = 1'b1;
`endif

  // txd is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      txd      <= 1'b1;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tstart && send_ok) begin
            shreg    <= tbus;
            baud_cnt <= '0;
            state    <= START;
            txd      <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            txd      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              txd <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Self-checking bench for midi_uart_tx: directed scenarios plus randomized bytes,
// checked cycle by cycle against the expected 8N1 waveform.
module tb_midi_uart_tx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 31250;
  localparam int CPB             = CLK_HZ / BAUD;
  localparam int FRAME           = 10 * CPB;

  logic       clk;
  logic       resetn;
  logic [7:0] tbus;
  logic       tstart;
  logic       tready;
  logic       txd;

  int checks;
  int errors;
  logic [7:0] rs_last;

  midi_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .tbus   (tbus),
    .tstart (tstart),
    .tready (tready),
    .txd    (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decision: does the block put this byte on the wire?
  task automatic rs_model(input logic [7:0] b, output bit tx);
    tx = 1'b1;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (b >= 8'h80 && b <= 8'hEF) begin
      if (b == rs_last) tx = 1'b0;
      else rs_last = b;
    end else if (b >= 8'hF0 && b <= 8'hF7) begin
      rs_last = 8'h00;
    end
`endif
  endtask

  // Handshake one byte and check every cycle of the resulting line activity.
  // spur_at / rst_at: cycle offsets after acceptance for an ignored tstart or
  // a mid-frame reset (-1 = none).
  task automatic send(input logic [7:0] b, input bit exp_tx, input int spur_at, input int rst_at);
    int n;
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    n = 0;
    @(negedge clk);
    while (!tready && n < 2 * FRAME + 10) begin
      @(negedge clk);
      n++;
    end
    check("wait_tready", tready, 1);
    tbus   = b;
    tstart = 1'b1;
    #1 check("tready_low_in_tstart", tready, 0);
    @(posedge clk);
    #1 tstart = 1'b0;
    tbus = 8'($urandom);
    if (!exp_tx) begin
      @(negedge clk);
      check("drop_txd_idle", txd, 1);
      check("drop_tready", tready, 1);
      return;
    end
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      check("txd_bit", txd, frame[j / CPB]);
      check("tready_busy", tready, 0);
      if (j == rst_at) begin
        resetn = 1'b0;
        #1;
        check("rst_txd_async", txd, 1);
        check("rst_tready_async", tready, 1);
        repeat (3) begin
          @(negedge clk);
          check("rst_txd_hold", txd, 1);
          check("rst_tready_hold", tready, 1);
        end
        resetn  = 1'b1;
        rs_last = 8'h00;
        return;
      end
      if (j == spur_at) begin
        tbus   = 8'h55;
        tstart = 1'b1;
      end else begin
        tstart = 1'b0;
        tbus   = 8'($urandom);
      end
    end
    @(negedge clk);
    check("idle_txd", txd, 1);
    check("idle_tready", tready, 1);
  endtask

  initial begin
    bit tx;
    logic [7:0] b;
    logic [7:0] seq [3];
    checks  = 0;
    errors  = 0;
    rs_last = 8'h00;
    resetn  = 1'b0;
    tstart  = 1'b0;
    tbus    = 8'h00;

    repeat (3) begin
      @(negedge clk);
      check("reset_txd", txd, 1);
      check("reset_tready", tready, 1);
    end
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_reset_txd", txd, 1);
      check("post_reset_tready", tready, 1);
    end

    rs_model(8'h90, tx);
    send(8'h90, tx, -1, -1);

    seq = '{8'h90, 8'h3C, 8'h40};
    foreach (seq[i]) begin
      rs_model(seq[i], tx);
      send(seq[i], tx, -1, -1);
    end

    rs_model(8'hAA, tx);
    send(8'hAA, tx, 100, -1);
    repeat (5) begin
      @(negedge clk);
      check("after_spur_idle", txd, 1);
    end

    rs_model(8'hC3, tx);
    send(8'hC3, tx, -1, 150);
    rs_model(8'h3C, tx);
    send(8'h3C, tx, -1, -1);
    send(8'h00, 1'b1, -1, -1);

`ifdef MIDI_TX_RUNNING_STATUS_EN
    begin
      logic [7:0] rs_bytes [13];
      bit         rs_send  [13];
      rs_bytes = '{8'h90, 8'h3C, 8'h40, 8'h90, 8'h3E, 8'h40, 8'hF8, 8'h90,
                   8'hF0, 8'h90, 8'h3C, 8'h40, 8'h90};
      rs_send  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      resetn = 1'b0;
      @(negedge clk);
      resetn  = 1'b1;
      rs_last = 8'h00;
      foreach (rs_bytes[i]) begin
        rs_model(rs_bytes[i], tx);
        send(rs_bytes[i], rs_send[i], -1, -1);
      end
    end
`endif

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 4))
        0: b = 8'h90;
        1: b = 8'hF0 | 8'($urandom_range(0, 15));
        2: b = 8'h80 | 8'($urandom_range(0, 3));
        default: b = 8'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rs_model(b, tx);
      send(b, tx, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FRAME - 2)) : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
